ulpi_tx_arbiter: RTL and testbench

- Shares the ULPI transmit path (DATA_OUT/STP) between two requesters:
  - a PHY register-write port, used by boot/configuration logic, e.g. SET_FUNCTION_CONTROL;
  - a USB packet-transmit port.
- Sequences TX-command, data and STP phases against PHY NXT/DIR.
- Arbitrates round-robin between the two ports, and handles abort, underrun and timeout.
- Sits between the system-side logic and the ULPI pins, in the CLK_USB domain.

---
 rtl/ulpi_tx_arbiter.sv | 87 ++++++++
 tb/tb_ulpi_tx_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ulpi_tx_arbiter.sv
// ulpi_tx_arbiter: round-robin share of the ULPI transmit path between PHY register writes and USB packets
module ulpi_tx_arbiter #(
  parameter int NXT_TIMEOUT = 255
) (
  input  logic       CLK_USB,
  input  logic       SYS_RST,
  input  logic       DIR,
  input  logic       NXT,
  output logic       STP,
  output logic [7:0] DATA_OUT,
  input  logic       reg_req,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       reg_ack,
  input  logic       pkt_req,
  input  logic [3:0] pkt_pid,
  input  logic [7:0] pkt_data,
  input  logic       pkt_valid,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic       pkt_done,
  output logic       abort,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, REG_CMD, REG_DATA, PKT_CMD, PKT_DATA, STOP, WAIT_DIR} state_t;
  state_t     state_q;
  logic       dir_q, last_pkt_q, err_q, src_pkt_q;
  logic [7:0] tmo_q;
  logic       xfer, tmo_hit, grant, grant_pkt;
  assign xfer      = state_q inside {REG_CMD, REG_DATA, PKT_CMD, PKT_DATA};
  assign tmo_hit   = tmo_q == 8'(NXT_TIMEOUT - 1);
  assign grant     = !DIR && !dir_q && (reg_req || pkt_req);
  // on a tie the port that did not win last time gets the bus
  assign grant_pkt = pkt_req && (!reg_req || !last_pkt_q);
  always_ff @(posedge CLK_USB) begin
    if (SYS_RST) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      last_pkt_q <= 1'b1;
      err_q      <= 1'b0;
      src_pkt_q  <= 1'b0;
      tmo_q      <= 8'h00;
    end else begin
      dir_q <= DIR;
      tmo_q <= (!xfer || NXT || DIR) ? 8'h00 : tmo_q + 8'd1;
      if (xfer && DIR) state_q <= WAIT_DIR;
      else if (xfer && !NXT && tmo_hit) begin
        state_q <= STOP;
        err_q   <= 1'b1;
      end else
        case (state_q)
          IDLE: if (grant) begin
            state_q    <= grant_pkt ? PKT_CMD : REG_CMD;
            last_pkt_q <= grant_pkt;
            src_pkt_q  <= grant_pkt;
          end
          REG_CMD: if (NXT) state_q <= REG_DATA;
          REG_DATA: if (NXT) begin
            state_q <= STOP;
            err_q   <= 1'b0;
          end
          PKT_CMD: if (NXT) state_q <= PKT_DATA;
          PKT_DATA: if (NXT && (!pkt_valid || pkt_last)) begin
            state_q <= STOP;
            err_q   <= !pkt_valid;
          end
          STOP: state_q <= IDLE;
          WAIT_DIR: if (!DIR) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
    end
  end
  always_comb begin
    DATA_OUT  = DIR                  ? 8'h00 :
                state_q == REG_CMD   ? {2'b10, reg_addr} :
                state_q == REG_DATA  ? reg_data :
                state_q == PKT_CMD   ? {4'b0100, pkt_pid} :
                state_q == PKT_DATA  ? pkt_data :
                state_q == STOP      ? {8{err_q}} : 8'h00;
    STP       = state_q == STOP && !DIR;
    reg_ack   = state_q == STOP && !err_q && !src_pkt_q;
    pkt_done  = state_q == STOP && !err_q && src_pkt_q;
    pkt_ready = state_q == PKT_DATA && NXT && pkt_valid && !DIR;
    abort     = (state_q == STOP && err_q) || (xfer && DIR);
    busy      = state_q != IDLE;
  end
endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// tb_ulpi_tx_arbiter: per-cycle vector table with a scoreboard queue of expected pin states
module tb_ulpi_tx_arbiter;
  logic       clk = 1'b0, rst, dir, nxt, stp;
  logic [7:0] data_out, pkt_data;
  logic       reg_req, reg_ack, pkt_req, pkt_valid, pkt_last, pkt_ready, pkt_done, abort, busy;
  logic [5:0] reg_addr = 6'h04;
  logic [7:0] reg_data = 8'h48;
  logic [3:0] pkt_pid = 4'h3;
  int         n_chk = 0, n_pass = 0;

  ulpi_tx_arbiter dut (
    .CLK_USB(clk), .SYS_RST(rst), .DIR(dir), .NXT(nxt), .STP(stp), .DATA_OUT(data_out),
    .reg_req(reg_req), .reg_addr(reg_addr), .reg_data(reg_data), .reg_ack(reg_ack),
    .pkt_req(pkt_req), .pkt_pid(pkt_pid), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .pkt_last(pkt_last), .pkt_ready(pkt_ready), .pkt_done(pkt_done), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  // in = {rst, reg_req, pkt_req, DIR, NXT, pkt_valid, pkt_last}
  // exp = {STP, DATA_OUT, reg_ack, pkt_ready, pkt_done, abort, busy}
  typedef struct {
    logic [6:0]  in;
    logic [7:0]  pd;
    logic [13:0] exp;
    string       name;
  } vec_t;
  typedef struct {
    logic [13:0] exp;
    string       name;
  } sb_t;
  vec_t tbl[$];
  sb_t  sb_q[$];

  function automatic void add(string n, logic [6:0] in, logic [7:0] pd, logic s, logic [7:0] d, logic [4:0] f);
    vec_t v;
    v.in = in; v.pd = pd; v.exp = {s, d, f}; v.name = n;
    tbl.push_back(v);
  endfunction

  task automatic step(vec_t v);
    sb_t e;
    logic [13:0] act;
    @(negedge clk);
    {rst, reg_req, pkt_req, dir, nxt, pkt_valid, pkt_last} = v.in;
    pkt_data = v.pd;
    sb_q.push_back('{v.exp, v.name});
    #2;
    e = sb_q.pop_front();
    act = {stp, data_out, reg_ack, pkt_ready, pkt_done, abort, busy};
    n_chk++;
    if (act === e.exp) n_pass++;
    else $display("FAIL %s: got stp=%b data=%h ack/rdy/done/abort/busy=%b, want stp=%b data=%h ack/rdy/done/abort/busy=%b",
                  e.name, act[13], act[12:5], act[4:0], e.exp[13], e.exp[12:5], e.exp[4:0]);
  endtask

  initial begin
    {rst, reg_req, pkt_req, dir, nxt, pkt_valid, pkt_last} = 7'b1000000;
    pkt_data = 8'h00;
    add("rst",           7'b1000000, 8'h00, 0, 8'h00, 5'b00000);
    add("rw_idle",       7'b0100000, 8'h00, 0, 8'h00, 5'b00000);
    add("rw_cmd",        7'b0100000, 8'h00, 0, 8'h84, 5'b00001);
    add("rw_cmd_nxt",    7'b0100100, 8'h00, 0, 8'h84, 5'b00001);
    add("rw_data",       7'b0100000, 8'h00, 0, 8'h48, 5'b00001);
    add("rw_data_nxt",   7'b0100100, 8'h00, 0, 8'h48, 5'b00001);
    add("rw_stop",       7'b0100000, 8'h00, 1, 8'h00, 5'b10001);
    add("rw_idle2",      7'b0000000, 8'h00, 0, 8'h00, 5'b00000);
    add("rs_grant",      7'b0100000, 8'h00, 0, 8'h00, 5'b00000);
    add("rs_cmd",        7'b0100100, 8'h00, 0, 8'h84, 5'b00001);
    add("rs_data",       7'b1100000, 8'h00, 0, 8'h48, 5'b00001);
    add("rs_after",      7'b0000000, 8'h00, 0, 8'h00, 5'b00000);
    add("tie_idle",      7'b0110000, 8'h00, 0, 8'h00, 5'b00000);
    add("tie_reg_cmd",   7'b0110100, 8'h00, 0, 8'h84, 5'b00001);
    add("tie_reg_data",  7'b0110100, 8'h00, 0, 8'h48, 5'b00001);
    add("tie_reg_stop",  7'b0110000, 8'h00, 1, 8'h00, 5'b10001);
    add("tie2_idle",     7'b0110000, 8'h00, 0, 8'h00, 5'b00000);
    add("tie2_pkt_cmd",  7'b0110100, 8'h00, 0, 8'h43, 5'b00001);
    add("tie2_pkt_data", 7'b0110111, 8'h5A, 0, 8'h5A, 5'b01001);
    add("tie2_pkt_stop", 7'b0110000, 8'h00, 1, 8'h00, 5'b00101);
    add("tie3_idle",     7'b0110000, 8'h00, 0, 8'h00, 5'b00000);
    add("tie3_reg_cmd",  7'b0100100, 8'h00, 0, 8'h84, 5'b00001);
    add("tie3_reg_data", 7'b0100100, 8'h00, 0, 8'h48, 5'b00001);
    add("tie3_reg_stop", 7'b0100000, 8'h00, 1, 8'h00, 5'b10001);
    add("tie3_idle2",    7'b0000000, 8'h00, 0, 8'h00, 5'b00000);
    add("pk_idle",       7'b0010000, 8'h00, 0, 8'h00, 5'b00000);
    add("pk_cmd",        7'b0010100, 8'h00, 0, 8'h43, 5'b00001);
    add("pk_a1_wait",    7'b0010010, 8'hA1, 0, 8'hA1, 5'b00001);
    add("pk_a1",         7'b0010110, 8'hA1, 0, 8'hA1, 5'b01001);
    add("pk_b2",         7'b0010110, 8'hB2, 0, 8'hB2, 5'b01001);
    add("pk_c3_inval",   7'b0010000, 8'hC3, 0, 8'hC3, 5'b00001);
    add("pk_c3",         7'b0010111, 8'hC3, 0, 8'hC3, 5'b01001);
    add("pk_stop",       7'b0010000, 8'h00, 1, 8'h00, 5'b00101);
    add("pk_idle2",      7'b0000000, 8'h00, 0, 8'h00, 5'b00000);
    add("da_idle",       7'b0010000, 8'h00, 0, 8'h00, 5'b00000);
    add("da_cmd",        7'b0010100, 8'h00, 0, 8'h43, 5'b00001);
    add("da_a1",         7'b0010110, 8'hA1, 0, 8'hA1, 5'b01001);
    add("da_dir",        7'b0011110, 8'hB2, 0, 8'h00, 5'b00011);
    add("da_wait",       7'b0011000, 8'h00, 0, 8'h00, 5'b00001);
    add("da_fall",       7'b0010000, 8'h00, 0, 8'h00, 5'b00001);
    add("da_idle2",      7'b0010000, 8'h00, 0, 8'h00, 5'b00000);
    add("da_retry",      7'b0010000, 8'h00, 0, 8'h43, 5'b00001);
    add("ur_cmd_nxt",    7'b0010100, 8'h00, 0, 8'h43, 5'b00001);
    add("ur_nxt_nov",    7'b0010100, 8'h77, 0, 8'h77, 5'b00001);
    add("ur_stop",       7'b0010000, 8'h00, 1, 8'hFF, 5'b00011);
    add("ur_idle",       7'b0000000, 8'h00, 0, 8'h00, 5'b00000);
    add("di_block",      7'b0101000, 8'h00, 0, 8'h00, 5'b00000);
    add("di_turn",       7'b0100000, 8'h00, 0, 8'h00, 5'b00000);
    add("di_grant",      7'b0100000, 8'h00, 0, 8'h00, 5'b00000);
    foreach (tbl[i]) step(tbl[i]);
    // NXT held low in REG_CMD: 255 silent cycles, then the error STOP
    for (int k = 1; k <= 255; k++) step('{7'b0100000, 8'h00, {1'b0, 8'h84, 5'b00001}, $sformatf("to_wait%0d", k)});
    step('{7'b0100000, 8'h00, {1'b1, 8'hFF, 5'b00011}, "to_stop"});
    step('{7'b0000000, 8'h00, {1'b0, 8'h00, 5'b00000}, "to_idle"});
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
